// File: rtl/reg_file_bank_pkg.sv
// Shared types and defaults for the flip-flop register-file bank.
// The optional write counter is enabled with REG_FILE_BANK_WRCNT_EN.
package reg_file_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;
   localparam int WRCNT_W   = 16;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

endpackage

// File: rtl/reg_file_bank_btn_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for a raw board button.
// Emits a single-cycle strobe per low-to-high transition; no debounce.
module btn_edge_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn,
   output logic o_stb
);

   logic r_s1;
   logic r_s2;
   logic r_s3;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= i_btn;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign o_stb = r_s2 & ~r_s3;

endmodule

// File: rtl/reg_file_bank.sv
// DEPTH x WIDTH flip-flop register file with button-strobed writes, registered
// read and a clear sweep. Optional write counter: REG_FILE_BANK_WRCNT_EN.
module reg_file_bank
   import reg_file_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int DEPTH = DEF_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_btn,
   input  logic [AW-1:0]       addr,
   input  logic [WIDTH-1:0]    wr_data,
   input  logic                clr,
   output logic [WIDTH-1:0]    rd_data,
   output logic                wr_ack,
   output logic                busy,
`ifdef REG_FILE_BANK_WRCNT_EN
   output logic [WRCNT_W-1:0]  wr_count,
`endif
   output state_t              dbg_state
);

   localparam logic [AW:0]   DEPTH_V = DEPTH[AW:0];
   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

   logic               w_wr_stb;
   logic               w_addr_ok;
   logic               w_do_write;
   logic               w_last;

   state_t             r_state;
   logic [AW-1:0]      r_ptr;
   logic               r_busy;
   logic               r_wr_ack;
   logic [WIDTH-1:0]   r_rd_data;
   logic [WIDTH-1:0]   r_mem [DEPTH];

   btn_edge_sync u_btn_sync (
      .i_clk (clk),
      .i_rst (rst),
      .i_btn (wr_btn),
      .o_stb (w_wr_stb)
   );

   // Addresses at or above DEPTH exist only when DEPTH is not a power of two.
   assign w_addr_ok  = {1'b0, addr} < DEPTH_V;
   assign w_do_write = (r_state == IDLE) & ~clr & w_wr_stb & w_addr_ok;
   assign w_last     = (r_ptr == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (clr) begin
                  r_state <= CLEAR;
                  r_ptr   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            CLEAR: begin
               r_ptr <= r_ptr + AW'(1);
               if (w_last) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (r_state == CLEAR) begin
         r_mem[r_ptr] <= '0;
      end else if (w_do_write) begin
         r_mem[addr] <= wr_data;
      end
   end

   // Reads sample the pre-edge array, so a same-cycle write returns the old word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_data <= '0;
         r_wr_ack  <= 1'b0;
      end else begin
         r_rd_data <= w_addr_ok ? r_mem[addr] : '0;
         r_wr_ack  <= w_do_write;
      end
   end

`ifdef REG_FILE_BANK_WRCNT_EN
   logic [WRCNT_W-1:0] r_wr_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_count <= '0;
      end else if (r_wr_ack && (r_wr_count != '1)) begin
         r_wr_count <= r_wr_count + WRCNT_W'(1);
      end
   end

   assign wr_count = r_wr_count;
`endif

   assign rd_data   = r_rd_data;
   assign wr_ack    = r_wr_ack;
   assign busy      = r_busy;
   assign dbg_state = r_state;

endmodule
